lut_sweep_eval: RTL and testbench
=================================

// Module: lut_sweep_eval
// PURPOSE
//  Parametrised, sequential successor to the fixed 4-input gate-level functions.
//  - Holds an N_IN-input boolean function as a runtime-loaded truth table.
//  - On start, sweeps every input combination 0..2^N_IN-1 in order.
//  - Streams each row out over a valid/ready handshake and counts true minterms.
//  - Serves as a reusable stimulus/checker engine for combinational guide blocks.
// PARAMETERS
//  N_IN   4   number of function inputs; legal range 1..8
//  TT_W   2**N_IN   truth-table width (derived; do not override)
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-high reset
//  start       in   1       begin a sweep; sampled only in IDLE or DONE
//  abort       in   1       synchronous cancel of a sweep in progress
//  tt_in       in   TT_W    truth table; bit i = f(row i); latched on accepted start
//  row_ready   in   1       consumer accepts the current row
//  row_valid   out  1       row_in/row_out are valid
//  row_in      out  N_IN    current input combination (MSB = first input)
//  row_out     out  1       f(row_in) taken from the latched table
//  ones_count  out  N_IN+1  number of transferred rows with row_out=1
//  busy        out  1       high in SWEEP
//  done        out  1       sticky; set after the last row transfers
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; table=0; row_valid=0; row_in=0;
//    row_out=0; ones_count=0; busy=0; done=0.
//  - FSM states are IDLE, SWEEP and DONE.
//    IDLE/DONE + start: latch tt_in, clear ones_count and done, set index=0,
//      go to SWEEP.
//    SWEEP: row_valid=1, row_in=index, row_out=table[index].
//    Transfer = row_valid & row_ready at a clock edge.
//      - ones_count += row_out.
//      - If index == 2^N_IN-1: go to DONE, done=1, row_valid=0.
//      - Otherwise index increments by 1.
//    No transfer: row_in, row_out and row_valid are held stable.
//    DONE: outputs hold, ones_count is frozen, done=1 until the next accepted start.
//  - Latency: row 0 is valid the cycle after start is sampled.
//    Full sweep takes 2^N_IN cycles with row_ready held high.
//  - Width: ones_count is N_IN+1 bits, so an all-ones table gives exactly 2^N_IN
//    and never wraps. index is N_IN+1 bits internally, so the last-row compare
//    cannot alias.
//  - abort in SWEEP: next state IDLE, row_valid=0, busy=0, done stays 0,
//    ones_count keeps its partial value.
//  - start and abort in the same cycle: abort wins, start is ignored.
//  - start while in SWEEP (including the last-transfer cycle) is ignored.
//  - tt_in changes during SWEEP have no effect; only the latched copy is used.
//  - reset mid-sweep: immediate return to reset values; no partial done.
// CONFIGURATION
//  LUT_SWEEP_CHECK_EN defined: adds the ports below; the block acts as a checker
//  for an external combinational DUT driven from row_in.
//    ext_f       in   1       DUT output for row_in
//    mism_count  out  N_IN+1  rows where ext_f != row_out, counted on transfer
//                             (reset 0, cleared on accepted start)
//    mism_any    out  1       sticky OR of mismatches
//  LUT_SWEEP_CHECK_EN undefined: these ports and this logic are absent;
//  all other behaviour is identical.
// TESTING (N_IN=4 unless noted)
//  1. tt_in=16'hA5C3, start pulse, row_ready=1
//     -> 16 transfers on 16 consecutive cycles;
//     -> row_out sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1;
//     -> done=1, ones_count=8.
//  2. tt_in=16'h0000 -> ones_count=0; tt_in=16'hFFFF -> ones_count=5'd16, no wrap.
//  3. row_ready low for 3 cycles at row 6, tt_in=16'hA5C3
//     -> row_in=6, row_out=1 and row_valid=1 held for 3 cycles;
//     -> sweep still ends with ones_count=8.
//  4. abort asserted with start in the same cycle during SWEEP at row 5
//     -> IDLE next cycle, row_valid=0, done=0, ones_count=partial value, start ignored.
//  5. reset asserted asynchronously mid-sweep (between edges)
//     -> all outputs reach reset values immediately;
//     -> a new start runs a full 16-row sweep.
//  6. LUT_SWEEP_CHECK_EN defined, N_IN=3, tt_in=8'hE8 (majority),
//     ext_f = majority, but bit 7 of the DUT output is forced to 0
//     -> mism_count=1, mism_any=1, ones_count=4.

Source files
------------

// File: rtl/lut_sweep_eval.sv
// lut_sweep_eval: sweeps a runtime-loaded N_IN-input truth table row by row over a
// valid/ready stream and counts true minterms. Define LUT_SWEEP_CHECK_EN for checker ports.
module lut_sweep_eval #(
    parameter int N_IN = 4,
    parameter int TT_W = 2**N_IN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] tt_in,
    input  logic            row_ready,
`ifdef LUT_SWEEP_CHECK_EN
    input  logic            ext_f,
    output logic [N_IN:0]   mism_count,
    output logic            mism_any,
`endif
    output logic            row_valid,
    output logic [N_IN-1:0] row_in,
    output logic            row_out,
    output logic [N_IN:0]   ones_count,
    output logic            busy,
    output logic            done
);
    // state | meaning
    // IDLE  | no sweep running, nothing presented
    // SWEEP | presenting rows, waiting for transfers
    // DONE  | last row transferred, results frozen until next start
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} stateT;

    localparam logic [N_IN:0] LAST_IDX = {1'b0, {N_IN{1'b1}}};
    localparam logic [N_IN:0] ONE      = {{N_IN{1'b0}}, 1'b1};

    stateT           state;
    logic [TT_W-1:0] ttLatch;
    logic [N_IN:0]   index;
    logic [N_IN:0]   indexNext;
    logic [N_IN:0]   rowOutExt;
    logic            xfer;
    logic            startAccept;

    assign indexNext   = index + ONE;
    assign rowOutExt   = {{N_IN{1'b0}}, row_out};
    assign xfer        = row_valid & row_ready;
    // abort outranks start in every state
    assign startAccept = (state == IDLE || state == DONE) && start && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ttLatch    <= '0;
            index      <= '0;
            row_valid  <= 1'b0;
            row_in     <= '0;
            row_out    <= 1'b0;
            ones_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (startAccept) begin
                        state      <= SWEEP;
                        ttLatch    <= tt_in;
                        index      <= '0;
                        row_valid  <= 1'b1;
                        row_in     <= '0;
                        row_out    <= tt_in[0];
                        ones_count <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                SWEEP: begin
                    // an abort cycle never counts as a transfer
                    if (abort) begin
                        state     <= IDLE;
                        row_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (xfer) begin
                        ones_count <= ones_count + rowOutExt;
                        if (index == LAST_IDX) begin
                            state     <= DONE;
                            row_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            index   <= indexNext;
                            row_in  <= indexNext[N_IN-1:0];
                            row_out <= ttLatch[indexNext[N_IN-1:0]];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LUT_SWEEP_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mism_count <= '0;
            mism_any   <= 1'b0;
        end else if (startAccept) begin
            mism_count <= '0;
            mism_any   <= 1'b0;
        end else if (state == SWEEP && !abort && xfer && (ext_f != row_out)) begin
            mism_count <= mism_count + ONE;
            mism_any   <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lut_sweep_eval.sv
// Scoreboard bench for lut_sweep_eval: the driver queues expected rows per sweep,
// a negedge monitor pops and compares on every transfer.
module tb_lut_sweep_eval;
    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         row_ready = 1'b0;
    logic [W-1:0] tt_in = '0;
    logic         row_valid, row_out, busy, done;
    logic [N-1:0] row_in;
    logic [N:0]   ones_count;
`ifdef LUT_SWEEP_CHECK_EN
    logic         ext_f;
    logic [N:0]   mism_count;
    logic         mism_any;
    logic [W-1:0] extTable = '0;
    // external function copy with its last row deliberately wrong
    assign ext_f = extTable[row_in] ^ (&row_in);
`endif

    int total = 0;
    int bad = 0;

    typedef struct { int row; logic f; } expT;
    expT expQ[$];

    lut_sweep_eval #(.N_IN(N)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .tt_in(tt_in), .row_ready(row_ready),
`ifdef LUT_SWEEP_CHECK_EN
        .ext_f(ext_f), .mism_count(mism_count), .mism_any(mism_any),
`endif
        .row_valid(row_valid), .row_in(row_in), .row_out(row_out),
        .ones_count(ones_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int countOnes(input logic [W-1:0] tt, input int rows);
        int s = 0;
        for (int i = 0; i < rows; i++) s += int'(tt[i]);
        return s;
    endfunction

    // monitor: transfers pop the scoreboard, stalls must hold the presented row
    logic         stallSeen = 1'b0;
    logic [N-1:0] stallRow;
    logic         stallOut;
    always @(negedge clk) begin
        expT e;
        if (reset) begin
            stallSeen = 1'b0;
        end else begin
            if (stallSeen) begin
                check("stallValid", row_valid, 1);
                check("stallRow", row_in, stallRow);
                check("stallOut", row_out, stallOut);
            end
            stallSeen = row_valid && !row_ready && !abort;
            stallRow  = row_in;
            stallOut  = row_out;
            if (row_valid && row_ready) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpectedRow: got row %0d, expected no transfer", row_in);
                end else begin
                    e = expQ.pop_front();
                    check("rowIn", row_in, e.row);
                    check("rowOut", row_out, e.f);
                end
            end
        end
    end

    // called #1 after a posedge; returns #1 after the start edge
    task automatic startSweep(input logic [W-1:0] tt);
        tt_in = tt;
        start = 1'b1;
        for (int i = 0; i < W; i++) expQ.push_back('{i, tt[i]});
`ifdef LUT_SWEEP_CHECK_EN
        extTable = tt;
`endif
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input bit randReady, output int cycles);
        cycles = 0;
        while (!done && cycles < 300) begin
            row_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        row_ready = 1'b1;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL doneTimeout: got done=0 after %0d cycles, expected done=1", cycles);
        end
    endtask

    task automatic finishCheck(input logic [W-1:0] tt);
        check("doneSet", done, 1);
        check("busyLow", busy, 0);
        check("validLow", row_valid, 0);
        check("onesCount", ones_count, countOnes(tt, W));
        check("lastRowHeld", row_in, W - 1);
        check("queueEmpty", expQ.size(), 0);
`ifdef LUT_SWEEP_CHECK_EN
        check("mismCount", mism_count, 1);
        check("mismAny", mism_any, 1);
`endif
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "Valid"}, row_valid, 0);
        check({tag, "RowIn"}, row_in, 0);
        check({tag, "RowOut"}, row_out, 0);
        check({tag, "Ones"}, ones_count, 0);
        check({tag, "Busy"}, busy, 0);
        check({tag, "Done"}, done, 0);
`ifdef LUT_SWEEP_CHECK_EN
        check({tag, "Mism"}, mism_count, 0);
`endif
    endtask

    initial begin
        int cycles;
        logic [W-1:0] tt;

        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // full sweep with ready held high: 16 transfers, 16 cycles
        startSweep(16'hA5C3);
        check("row0Latency", row_valid, 1);
        check("busyHigh", busy, 1);
        waitDone(1'b0, cycles);
        check("sweepCycles", cycles, W);
        finishCheck(16'hA5C3);

        // table extremes; these start from DONE
        startSweep(16'h0000);
        waitDone(1'b0, cycles);
        finishCheck(16'h0000);
        startSweep(16'hFFFF);
        waitDone(1'b0, cycles);
        finishCheck(16'hFFFF);

        // back-pressure at row 6 for three cycles
        startSweep(16'hA5C3);
        row_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        row_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            check("stallRow6", row_in, 6);
            check("stallOut6", row_out, 1);
        end
        waitDone(1'b0, cycles);
        finishCheck(16'hA5C3);

        // abort together with start at row 5
        startSweep(16'hA5C3);
        row_ready = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        check("abortAtRow", row_in, 5);
        row_ready = 1'b0;
        abort = 1'b1;
        start = 1'b1;
        tt_in = 16'hFFFF;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        expQ.delete();
        check("abortValid", row_valid, 0);
        check("abortBusy", busy, 0);
        check("abortDone", done, 0);
        check("abortOnes", ones_count, countOnes(16'hA5C3, 5));
        row_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("abortStillIdle", row_valid, 0);
        check("abortOnesKept", ones_count, countOnes(16'hA5C3, 5));

        // asynchronous reset between edges mid-sweep
        startSweep(16'hA5C3);
        row_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        #1 reset = 1'b1;
        #1;
        checkResetValues("asyncReset");
        expQ.delete();
        #1 reset = 1'b0;
        @(posedge clk); #1;
        startSweep(16'hA5C3);
        waitDone(1'b0, cycles);
        check("postResetCycles", cycles, W);
        finishCheck(16'hA5C3);

        // start and a changing tt_in during a sweep must be ignored
        tt = W'($urandom);
        startSweep(tt);
        row_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b1;
        tt_in = ~tt;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(1'b1, cycles);
        finishCheck(tt);

        // random tables with random back-pressure
        for (int k = 0; k < 6; k++) begin
            tt = W'($urandom);
            startSweep(tt);
            waitDone(1'b1, cycles);
            finishCheck(tt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
